pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RV32I pipeline.
- Generates per-stage stall and flush strobes for pc_reg, if_id, id_ex and ex_mem, plus the redirect to pc_reg.
- Handles load-use bubbles, EX-resolved jumps/branches, multi-cycle EX operations, bus wait states and a debug halt with pipeline drain.
- Includes a saturating stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted after a halt request before halt_ack_o asserts.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs1_addr_i  in  5  rs1 of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_mem_re_i  in  1  instruction in EX is a load (id_ex mem_re_o).
- ex_rd_addr_i  in  5  rd of the instruction in EX.
- ex_jump_en_i  in  1  EX resolved a taken jump/branch.
- ex_jump_addr_i  in  32  jump target.
- ex_busy_i  in  1  multi-cycle EX operation not finished.
- bus_busy_i  in  1  data bus wait state.
- halt_req_i  in  1  debug halt request (level).
- perf_clr_i  in  1  synchronous clear of stall_cycles_o.
- stall_o  out  4  hold: [3] pc, [2] if_id, [1] id_ex, [0] ex_mem.
- flush_o  out  3  load NOP/zero: [2] if_id, [1] id_ex (drives id_ex hold_flag_i), [0] ex_mem.
- jump_en_o  out  1  redirect pc.
- jump_addr_o  out  32  redirect target.
- halt_ack_o  out  1  pipeline drained and halted.
- stall_cycles_o  out  CNT_W  saturating stall counter.

Behaviour:
- Consumer rules: flush beats stall within a register; jump_en_o beats stall_o[3] in pc_reg.
- While rst is low:
  - state RUN, drain counter 0, stall_cycles_o 0.
  - Outputs forced: stall_o 0, flush_o 3'b111, jump_en_o 0, jump_addr_o 0, halt_ack_o 0.
- All strobes are combinational from state and inputs (zero latency). State and counters are registered.
- Load-use hazard (lu): ex_mem_re_i && ex_rd_addr_i!=0 && ((id_rs1_used_i && id_rs1_addr_i==ex_rd_addr_i) || (id_rs2_used_i && id_rs2_addr_i==ex_rd_addr_i)).
- jump_addr_o = ex_jump_addr_i whenever jump_en_o=1, else 0.
- RUN, priority high to low:
  1. bus_busy_i: stall 4'b1111, flush 000, jump_en_o 0.
  2. ex_busy_i: stall 4'b1110, flush 3'b001, jump_en_o 0 (jump is taken only once EX completes).
  3. ex_jump_en_i: jump_en_o 1, flush 3'b110, stall 0. This squashes any concurrent lu.
  4. lu: stall 4'b1100, flush 3'b010.
  5. halt_req_i: stall 4'b1100, flush 3'b010; next state DRAIN, counter 0.
  6. Otherwise: all strobes 0.
- DRAIN:
  - bus_busy_i and ex_busy_i are handled as in RUN and freeze the counter.
  - Otherwise stall 4'b1100, flush 3'b010, counter +1.
  - ex_jump_en_i (not busy): jump_en_o 1, flush 3'b110. The PC still loads the target; the counter still increments.
  - halt_req_i low: next state RUN, counter cleared. Strobes this cycle are as if in RUN.
  - When counter reaches DRAIN_CYCLES-1 on an increment, next state HALTED.
- HALTED:
  - halt_ack_o 1, stall 4'b1100, flush 3'b010.
  - halt_req_i low: next state RUN; halt_ack_o drops in the same cycle (combinational).
- stall_cycles_o:
  - Increments each cycle with stall_o[3]=1 and jump_en_o=0.
  - Saturates at all-ones.
  - perf_clr_i sets it to 0 and beats an increment in the same cycle.
- Reset asserted mid-DRAIN or mid-HALTED returns to RUN immediately (asynchronous).

Decomposition:
- Shared defines: stage-index constants (STG_PC=3, STG_IFID=2, STG_IDEX=1, STG_EXMEM=0) and FSM state encoding (RUN, DRAIN, HALTED as a 2-bit typedef).
- Sub-module hazard_detect: combinational lu detection. Everything else stays in pipe_ctrl.

Test Plan:
- Load-use: ex_mem_re_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 -> stall_o=1100, flush_o=010 for exactly 1 cycle; stall_cycles_o +1. Repeat with rd=0 -> no stall.
- Jump + lu in the same cycle: ex_jump_en_i=1, ex_jump_addr_i=0x0000_0100 -> jump_en_o=1, jump_addr_o=0x100, flush_o=110, stall_o=0000.
- Bus wait with pending jump: bus_busy_i=1 for 3 cycles with ex_jump_en_i=1 -> stall_o=1111, jump_en_o=0 for those 3 cycles. Cycle 4 (busy low) -> jump_en_o=1.
- ex_busy_i=1 for 4 cycles -> stall_o=1110, flush_o=001 each cycle; stall_cycles_o +4.
- Halt drain (DRAIN_CYCLES=3): halt_req_i rises -> halt_ack_o=1 exactly 4 cycles later. Insert bus_busy_i for 2 cycles mid-drain -> ack delayed by 2. halt_req_i low -> halt_ack_o=0 same cycle; strobes clear once no hazard.
- Reset/saturation: rst low mid-DRAIN -> flush_o=111, halt_ack_o=0, state RUN. With CNT_W=4, 20 stall cycles -> stall_cycles_o=15; perf_clr_i -> 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and strobe helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned STG_PC     = 3;
    localparam int unsigned STG_IFID   = 2;
    localparam int unsigned STG_IDEX   = 1;
    localparam int unsigned STG_EXMEM  = 0;

    localparam int unsigned STALL_W    = 4;
    localparam int unsigned FLUSH_W    = 3;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [STALL_W-1:0] stall;
        logic [FLUSH_W-1:0] flush;
        logic               jump_en;
    } strobe_t;

    // Bubble insertion: hold PC and IF/ID, load a NOP into ID/EX; a jump squashes IF/ID too.
    function automatic strobe_t bubble_strobes(input logic jump);
        strobe_t s;
        s = '0;
        s.stall[STG_PC]   = 1'b1;
        s.stall[STG_IFID] = 1'b1;
        s.flush[STG_IDEX] = 1'b1;
        if (jump) begin
            s.flush[STG_IFID] = 1'b1;
            s.jump_en         = 1'b1;
        end
        return s;
    endfunction

    // Normal-run priority: bus wait, EX busy, jump, then load-use / halt bubble.
    function automatic strobe_t run_strobes(input logic bus_busy, input logic ex_busy,
                                            input logic jump, input logic hold);
        strobe_t s;
        s = '0;
        if (bus_busy) begin
            s.stall = '1;
        end else if (ex_busy) begin
            s.stall                  = '1;
            s.stall[STG_EXMEM]       = 1'b0;
            s.flush[STG_EXMEM]       = 1'b1;
        end else if (jump) begin
            s.jump_en                = 1'b1;
            s.flush[STG_IFID]        = 1'b1;
            s.flush[STG_IDEX]        = 1'b1;
        end else if (hold) begin
            s = bubble_strobes(1'b0);
        end
        return s;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the source registers of ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_re_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    output logic                  lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign lu_o    = ex_mem_re_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller with debug-halt drain and a saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_mem_re_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_jump_en_i,
    input  logic [XLEN-1:0]       ex_jump_addr_i,
    input  logic                  ex_busy_i,
    input  logic                  bus_busy_i,
    input  logic                  halt_req_i,
    input  logic                  perf_clr_i,
    output logic [STALL_W-1:0]    stall_o,
    output logic [FLUSH_W-1:0]    flush_o,
    output logic                  jump_en_o,
    output logic [XLEN-1:0]       jump_addr_o,
    output logic                  halt_ack_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               lu;
    logic               busy;
    logic               halt_ack_c;
    strobe_t            run_c;
    strobe_t            str_c;

    hazard_detect u_hazard_detect (
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_mem_re_i   (ex_mem_re_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .lu_o          (lu)
    );

    assign busy  = bus_busy_i || ex_busy_i;
    assign run_c = run_strobes(bus_busy_i, ex_busy_i, ex_jump_en_i, lu || halt_req_i);

    // Next state and zero-latency strobes
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        str_c       = run_c;
        halt_ack_c  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!busy && !ex_jump_en_i && !lu && halt_req_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!halt_req_i) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else if (!busy) begin
                    str_c       = bubble_strobes(ex_jump_en_i);
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) begin
                    state_d = ST_RUN;
                end else begin
                    str_c      = bubble_strobes(1'b0);
                    halt_ack_c = 1'b1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
        // Reset holds every stage empty regardless of inputs
        if (!rst) begin
            str_c       = '0;
            str_c.flush = '1;
            halt_ack_c  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if (str_c.stall[STG_PC] && !str_c.jump_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o        = str_c.stall;
    assign flush_o        = str_c.flush;
    assign jump_en_o      = str_c.jump_en;
    assign jump_addr_o    = str_c.jump_en ? ex_jump_addr_i : '0;
    assign halt_ack_o     = halt_ack_c;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned DRAIN = 3;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ld, jmp, exb, bus, halt, clr;
    logic [31:0] jaddr;

    logic [3:0]  s_o, s4_o;
    logic [2:0]  f_o, f4_o;
    logic        j_o, j4_o, ack_o, ack4_o;
    logic [31:0] a_o, a4_o;
    logic [31:0] cyc_o;
    logic [3:0]  cyc4_o;

    int          n_chk, n_pass;
    bit          m_halting, m_halted;
    int          m_bub;
    longint      m_c32, m_c4;
    logic        obs_ack;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .ex_mem_re_i(ld), .ex_rd_addr_i(rd), .ex_jump_en_i(jmp), .ex_jump_addr_i(jaddr),
        .ex_busy_i(exb), .bus_busy_i(bus), .halt_req_i(halt), .perf_clr_i(clr),
        .stall_o(s_o), .flush_o(f_o), .jump_en_o(j_o), .jump_addr_o(a_o),
        .halt_ack_o(ack_o), .stall_cycles_o(cyc_o)
    );

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .ex_mem_re_i(ld), .ex_rd_addr_i(rd), .ex_jump_en_i(jmp), .ex_jump_addr_i(jaddr),
        .ex_busy_i(exb), .bus_busy_i(bus), .halt_req_i(halt), .perf_clr_i(clr),
        .stall_o(s4_o), .flush_o(f4_o), .jump_en_o(j4_o), .jump_addr_o(a4_o),
        .halt_ack_o(ack4_o), .stall_cycles_o(cyc4_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0; ld = 1'b0;
        jmp = 1'b0; jaddr = 32'h0; exb = 1'b0; bus = 1'b0; clr = 1'b0;
    endtask

    // One clock: inputs are already driven; outputs are judged at the falling edge.
    task automatic step();
        logic       lu;
        logic [3:0] es;
        logic [2:0] ef;
        logic       ej, ea;
        bit         nh, nd;
        int         nb;
        @(negedge clk);
        if (!rst) begin
            m_halting = 1'b0; m_halted = 1'b0; m_bub = 0; m_c32 = 0; m_c4 = 0;
        end
        lu = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (bus)              begin es = 4'b1111; ef = 3'b000; ej = 1'b0; end
        else if (exb)         begin es = 4'b1110; ef = 3'b001; ej = 1'b0; end
        else if (jmp)         begin es = 4'b0000; ef = 3'b110; ej = 1'b1; end
        else if (lu || halt)  begin es = 4'b1100; ef = 3'b010; ej = 1'b0; end
        else                  begin es = 4'b0000; ef = 3'b000; ej = 1'b0; end
        ea = 1'b0;
        nh = m_halting; nd = m_halted; nb = m_bub;
        if (m_halted) begin
            if (halt) begin es = 4'b1100; ef = 3'b010; ej = 1'b0; ea = 1'b1; end
            else nd = 1'b0;
        end else if (m_halting) begin
            if (!halt) begin
                nh = 1'b0; nb = 0;
            end else if (!(bus || exb)) begin
                es = 4'b1100; ef = jmp ? 3'b110 : 3'b010; ej = jmp;
                nb = m_bub + 1;
                if (nb == int'(DRAIN)) begin nh = 1'b0; nd = 1'b1; nb = 0; end
            end
        end else if (!bus && !exb && !jmp && !lu && halt) begin
            nh = 1'b1; nb = 0;
        end
        if (!rst) begin es = 4'b0000; ef = 3'b111; ej = 1'b0; ea = 1'b0; end
        check("stall", 64'(s_o), 64'(es));
        check("flush", 64'(f_o), 64'(ef));
        check("jump_en", 64'(j_o), 64'(ej));
        check("jump_addr", 64'(a_o), ej ? 64'(jaddr) : 64'd0);
        check("halt_ack", 64'(ack_o), 64'(ea));
        check("cnt32", 64'(cyc_o), 64'(m_c32));
        check("stall_w4", 64'(s4_o), 64'(es));
        check("cnt4", 64'(cyc4_o), 64'(m_c4));
        obs_ack = ack_o;
        if (rst) begin
            m_halting = nh; m_halted = nd; m_bub = nb;
            if (clr) begin
                m_c32 = 0; m_c4 = 0;
            end else if (es[3] && !ej) begin
                if (m_c32 < 64'hFFFF_FFFF) m_c32++;
                if (m_c4 < 15) m_c4++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit got;
        clk = 1'b0; rst = 1'b0; halt = 1'b0; obs_ack = 1'b0;
        n_chk = 0; n_pass = 0;
        idle();
        step(); step();
        rst = 1'b1;
        step();

        // Load-use on rs2, then the same with rd = x0
        ld = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1; step();
        idle(); step();
        ld = 1'b1; rd = 5'd0; rs2 = 5'd0; u2 = 1'b1; step();
        idle(); step();

        // Jump squashes concurrent load-use
        ld = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1; jmp = 1'b1; jaddr = 32'h0000_0100; step();
        idle(); step();

        // Bus wait holds a pending jump
        jmp = 1'b1; jaddr = 32'h0000_2000; bus = 1'b1;
        repeat (3) step();
        bus = 1'b0; step();
        idle(); step();

        // Multi-cycle EX operation
        exb = 1'b1; repeat (4) step();
        idle(); step();

        // Halt drain latency
        halt = 1'b1; got = 1'b0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin step(); if (obs_ack) got = 1'b1; else lat++; end
        check("halt_lat", 64'(lat), 64'd4);
        halt = 1'b0; step(); step();

        // Halt drain with two bus wait cycles in the middle
        halt = 1'b1; got = 1'b0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            bus = (i == 2 || i == 3);
            step();
            if (obs_ack) got = 1'b1; else lat++;
        end
        bus = 1'b0;
        check("halt_lat_bus", 64'(lat), 64'd6);
        halt = 1'b0; step(); step();

        // Reset asserted mid-drain
        halt = 1'b1; step(); step();
        rst = 1'b0; step();
        rst = 1'b1; halt = 1'b0; step(); step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
            u1 = 1'($urandom); u2 = 1'($urandom); ld = 1'($urandom);
            jmp = ($urandom_range(0, 5) == 0); jaddr = $urandom;
            exb = ($urandom_range(0, 7) == 0); bus = ($urandom_range(0, 6) == 0);
            clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            rst = ($urandom_range(0, 150) != 0);
            step();
        end
        rst = 1'b1; halt = 1'b0; idle(); step(); step();

        // Saturation of the narrow counter
        clr = 1'b1; step(); clr = 1'b0;
        bus = 1'b1; repeat (20) step();
        bus = 1'b0;
        check("sat4", 64'(cyc4_o), 64'd15);
        check("cnt32_20", 64'(cyc_o), 64'd20);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr4", 64'(cyc4_o), 64'd0);
        check("clr32", 64'(cyc_o), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
